tamagotchi_core: RTL and testbench

- Pet state engine directly downstream of the sensor/button conditioning stage; consumes its binary flags (frio, calor, luz, cerca, jugar, alimentar, curar, test, reset strobes).
- Keeps four saturating stat levels and a decay timer, and derives a registered mood state for the display/sound stages.
- All stat updates happen on a slow tick strobe; mood is re-evaluated every clk.

---
 rtl/tamagotchi_core.sv | 212 +++++++++++++++++++++
 tb/tb_tamagotchi_core.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tamagotchi_core.sv
// ---------------------------------------------------------------------------
// tamagotchi_core
//
// Pet state engine. Holds four saturating stat levels (saciedad, animo,
// salud, energia), a decay timer and a registered mood (estado) for the
// display and sound stages. Stats move only on the slow tick strobe; the
// mood is re-evaluated on every clk from the registered stats.
//
// Optional feature (macro TAMA_AGE_EN): an age counter that bumps edad once
// every AGE_TICKS ticks, saturating at 255. Without the macro edad is 0.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   tick       one-clk slow strobe (~1 Hz)
//   frio, calor, luz, cerca      conditioned sensor levels
//   jugar, alimentar, curar      conditioned button levels
//   en_test    long-press strobe: toggles accelerated-decay mode
//   en_reset   long-press strobe: same effect as rst
//   saciedad, animo, salud, energia  stat levels, 0..MAX_LVL
//   estado     mood: 0 NEUTRAL 1 FELIZ 2 HAMBRIENTO 3 TRISTE 4 CANSADO
//                    5 ENFERMO 6 DORMIDO 7 MUERTO
//   test_mode  accelerated-decay mode active
//   edad       age (0 when TAMA_AGE_EN is not defined)
// ---------------------------------------------------------------------------
module tamagotchi_core #(
    parameter int MAX_LVL     = 5,
    parameter int DECAY_TICKS = 10,
    parameter int AGE_TICKS   = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       frio,
    input  logic       calor,
    input  logic       luz,
    input  logic       cerca,
    input  logic       jugar,
    input  logic       alimentar,
    input  logic       curar,
    input  logic       en_test,
    input  logic       en_reset,
    output logic [2:0] saciedad,
    output logic [2:0] animo,
    output logic [2:0] salud,
    output logic [2:0] energia,
    output logic [2:0] estado,
    output logic       test_mode,
    output logic [7:0] edad
);

    localparam logic [2:0] NEUTRAL    = 3'd0;
    localparam logic [2:0] FELIZ      = 3'd1;
    localparam logic [2:0] HAMBRIENTO = 3'd2;
    localparam logic [2:0] TRISTE     = 3'd3;
    localparam logic [2:0] CANSADO    = 3'd4;
    localparam logic [2:0] ENFERMO    = 3'd5;
    localparam logic [2:0] DORMIDO    = 3'd6;
    localparam logic [2:0] MUERTO     = 3'd7;

    localparam logic [2:0] LVL_MAX = 3'(MAX_LVL);
    localparam int         DW      = (DECAY_TICKS > 2) ? $clog2(DECAY_TICKS) : 1;
    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_TICKS - 1);

    if (MAX_LVL < 1 || MAX_LVL > 7 || DECAY_TICKS < 2 || AGE_TICKS < 1) begin : g_param_check
        $error("tamagotchi_core: parameter out of range");
    end

    // Add a signed delta to a stat and clamp the result to 0..MAX_LVL.
    function automatic logic [2:0] sat_add(input logic [2:0] v, input int delta);
        int r;
        r = int'(v) + delta;
        if (r < 0)       r = 0;
        if (r > MAX_LVL) r = MAX_LVL;
        return 3'(r);
    endfunction

    logic [DW-1:0] dcnt;
    logic          prev_jugar, prev_alimentar, prev_curar;

    logic          restart;
    logic          dead;
    logic          live_tick;
    logic          decay;
    logic          ev_jugar, ev_alimentar, ev_curar;
    logic          act_jugar, act_alimentar;
    logic [2:0]    saciedad_d, animo_d, salud_d, energia_d;
    logic [2:0]    mood_d;

    assign restart   = rst | en_reset;
    // salud = 0 is exactly the MUERTO condition; using it directly also
    // freezes the tick that would otherwise land before estado catches up.
    assign dead      = (salud == 3'd0);
    assign live_tick = tick & ~dead;

    // Button events are rising edges seen between consecutive ticks.
    assign ev_jugar     = jugar     & ~prev_jugar;
    assign ev_alimentar = alimentar & ~prev_alimentar;
    assign ev_curar     = curar     & ~prev_curar;

    // Healing pre-empts the other buttons; a sleeping pet eats and plays not.
    assign act_alimentar = ev_alimentar & ~ev_curar & (estado != DORMIDO);
    assign act_jugar     = ev_jugar     & ~ev_curar & (estado != DORMIDO);

    assign decay = test_mode | (dcnt == DECAY_LAST);

    // Next stat values for a live tick: decay first, then the button actions
    // on top of the decayed values.
    always_comb begin
        // NOTE: every variable gets a default before any branch so always_comb
        // never holds a value across evaluations (no inferred latch).
        saciedad_d = saciedad;
        animo_d    = animo;
        salud_d    = salud;
        energia_d  = energia;

        if (decay) begin
            saciedad_d = sat_add(saciedad, -1);
            if (!cerca) animo_d = sat_add(animo, -1);
            energia_d  = sat_add(energia, luz ? -1 : 1);
            salud_d    = sat_add(salud, -int'(frio | calor) - int'(saciedad == 3'd0));
        end

        if (act_alimentar) saciedad_d = sat_add(saciedad_d, 2);

        if (act_jugar && energia_d != 3'd0) begin
            animo_d   = sat_add(animo_d, 2);
            energia_d = sat_add(energia_d, -1);
        end

        if (ev_curar) salud_d = LVL_MAX;
    end

    // Mood from the current stats, highest priority first.
    always_comb begin
        mood_d = NEUTRAL;
        if (salud == 3'd0)
            mood_d = MUERTO;
        else if (!luz)
            mood_d = DORMIDO;
        else if (salud <= 3'd1 || frio || calor)
            mood_d = ENFERMO;
        else if (saciedad <= 3'd1)
            mood_d = HAMBRIENTO;
        else if (energia <= 3'd1)
            mood_d = CANSADO;
        else if (animo <= 3'd1)
            mood_d = TRISTE;
        else if (int'(animo) >= MAX_LVL - 1 && saciedad >= 3'd2 &&
                 salud >= 3'd2 && energia >= 3'd2)
            mood_d = FELIZ;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (restart) begin
            saciedad       <= LVL_MAX;
            animo          <= LVL_MAX;
            salud          <= LVL_MAX;
            energia        <= LVL_MAX;
            estado         <= NEUTRAL;
            test_mode      <= 1'b0;
            dcnt           <= '0;
            prev_jugar     <= 1'b0;
            prev_alimentar <= 1'b0;
            prev_curar     <= 1'b0;
        end else begin
            // A toggle on a tick clk takes effect from the following tick,
            // because this tick's decay already used the old test_mode.
            if (en_test) test_mode <= ~test_mode;
            estado <= mood_d;
            if (live_tick) begin
                saciedad       <= saciedad_d;
                animo          <= animo_d;
                salud          <= salud_d;
                energia        <= energia_d;
                dcnt           <= decay ? '0 : dcnt + DW'(1);
                prev_jugar     <= jugar;
                prev_alimentar <= alimentar;
                prev_curar     <= curar;
            end
        end
    end

`ifdef TAMA_AGE_EN
    localparam int AW = (AGE_TICKS > 1) ? $clog2(AGE_TICKS) : 1;
    localparam logic [AW-1:0] AGE_LAST = AW'(AGE_TICKS - 1);

    logic [AW-1:0] acnt;
    logic [7:0]    edad_q;

    always_ff @(posedge clk) begin
        if (restart) begin
            acnt   <= '0;
            edad_q <= 8'd0;
        end else if (live_tick) begin
            if (acnt == AGE_LAST) begin
                acnt <= '0;
                if (edad_q != 8'hFF) edad_q <= edad_q + 8'd1;
            end else begin
                acnt <= acnt + AW'(1);
            end
        end
    end

    assign edad = edad_q;
`else
    assign edad = 8'd0;
`endif

endmodule

// File: tb/tb_tamagotchi_core.sv
// ---------------------------------------------------------------------------
// tb_tamagotchi_core
//
// Directed bench for tamagotchi_core with MAX_LVL=5, DECAY_TICKS=4. Inputs
// change on the falling clock edge, outputs are checked on the falling edge,
// and every expected value below is worked out by hand from the behaviour of
// the pet engine.
// ---------------------------------------------------------------------------
module tb_tamagotchi_core;

    logic       clk = 1'b0;
    logic       rst, tick;
    logic       frio, calor, luz, cerca;
    logic       jugar, alimentar, curar;
    logic       en_test, en_reset;
    logic [2:0] saciedad, animo, salud, energia, estado;
    logic       test_mode;
    logic [7:0] edad;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tamagotchi_core #(
        .MAX_LVL    (5),
        .DECAY_TICKS(4),
        .AGE_TICKS  (60)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .frio     (frio),
        .calor    (calor),
        .luz      (luz),
        .cerca    (cerca),
        .jugar    (jugar),
        .alimentar(alimentar),
        .curar    (curar),
        .en_test  (en_test),
        .en_reset (en_reset),
        .saciedad (saciedad),
        .animo    (animo),
        .salud    (salud),
        .energia  (energia),
        .estado   (estado),
        .test_mode(test_mode),
        .edad     (edad)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One tick strobe, then one extra clk so estado has caught up as well.
    task automatic do_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    // Returns on the falling edge right after the reset edge.
    task automatic pulse_reset();
        @(negedge clk) en_reset = 1'b1;
        @(negedge clk) en_reset = 1'b0;
    endtask

    task automatic pulse_test();
        @(negedge clk) en_test = 1'b1;
        @(negedge clk) en_test = 1'b0;
    endtask

    task automatic check_stats(input string tag, input int s, input int a, input int h, input int e);
        check({tag, "_saciedad"}, 32'(saciedad), 32'(s));
        check({tag, "_animo"},    32'(animo),    32'(a));
        check({tag, "_salud"},    32'(salud),    32'(h));
        check({tag, "_energia"},  32'(energia),  32'(e));
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0;
        frio = 1'b0; calor = 1'b0; luz = 1'b1; cerca = 1'b0;
        jugar = 1'b0; alimentar = 1'b0; curar = 1'b0;
        en_test = 1'b0; en_reset = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_stats("rst", 5, 5, 5, 5);
        check("rst_estado", 32'(estado), 32'd0);
        check("rst_test_mode", 32'(test_mode), 32'd0);
        check("rst_edad", 32'(edad), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("feliz_after_rst", 32'(estado), 32'd1);

        // Normal decay: one event every 4 ticks.
        ticks(4);
        check_stats("decay4", 4, 4, 5, 4);
        check("decay4_estado", 32'(estado), 32'd1);
        ticks(4);
        check_stats("decay8", 3, 3, 5, 3);
        check("decay8_estado", 32'(estado), 32'd0);

        // Company keeps animo up.
        pulse_reset();
        check("en_reset_saciedad", 32'(saciedad), 32'd5);
        cerca = 1'b1;
        ticks(8);
        check_stats("cerca8", 3, 5, 5, 3);

        // Held alimentar yields one event only (ticks fall between decays).
        ticks(4);
        check("pre_feed_saciedad", 32'(saciedad), 32'd2);
        alimentar = 1'b1;
        ticks(3);
        alimentar = 1'b0;
        check("feed_once_saciedad", 32'(saciedad), 32'd4);
        check("feed_once_estado", 32'(estado), 32'd1);

        // jugar on a decay tick: animo 5-1+2 -> 5, energia 2-1-1 -> 0.
        cerca = 1'b0;
        jugar = 1'b1;
        do_tick();
        jugar = 1'b0;
        check_stats("play", 3, 5, 5, 0);

        // Test mode: decay every tick; jugar with energia 0 has no effect.
        pulse_reset();
        pulse_test();
        check("test_mode_on", 32'(test_mode), 32'd1);
        ticks(5);
        check_stats("fast5", 0, 0, 5, 0);
        jugar = 1'b1;
        do_tick();
        jugar = 1'b0;
        check_stats("play_no_energy", 0, 0, 4, 0);

        // curar priority: feed and play discarded, salud refilled.
        ticks(2);
        check("pre_cure_salud", 32'(salud), 32'd2);
        jugar = 1'b1; alimentar = 1'b1; curar = 1'b1;
        do_tick();
        jugar = 1'b0; alimentar = 1'b0; curar = 1'b0;
        check_stats("cure", 0, 0, 5, 0);

        // Cold and starving: salud -2 per tick until dead.
        frio = 1'b1;
        do_tick();
        check("cold1_salud", 32'(salud), 32'd3);
        do_tick();
        check("cold2_salud", 32'(salud), 32'd1);
        check("cold2_estado", 32'(estado), 32'd5);
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        check("dead_salud", 32'(salud), 32'd0);
        check("dead_estado_lag", 32'(estado), 32'd5);
        @(negedge clk);
        check("dead_estado", 32'(estado), 32'd7);

        // MUERTO freezes everything, even with the lights off and buttons.
        frio = 1'b0; luz = 1'b0; curar = 1'b1; alimentar = 1'b1;
        ticks(2);
        curar = 1'b0; alimentar = 1'b0;
        check_stats("frozen", 0, 0, 0, 0);
        check("frozen_estado", 32'(estado), 32'd7);
        luz = 1'b1;
        pulse_reset();
        check_stats("revive", 5, 5, 5, 5);
        check("revive_estado", 32'(estado), 32'd0);
        check("revive_test_mode", 32'(test_mode), 32'd0);

        // DORMIDO: feeding ignored, energia recovers up to MAX_LVL.
        pulse_test();
        ticks(2);
        check_stats("pre_sleep", 3, 3, 5, 3);
        @(negedge clk) luz = 1'b0;
        @(negedge clk);
        check("sleep_estado", 32'(estado), 32'd6);
        alimentar = 1'b1;
        do_tick();
        alimentar = 1'b0;
        check("sleep_feed_saciedad", 32'(saciedad), 32'd2);
        check("sleep_energia1", 32'(energia), 32'd4);
        ticks(2);
        check("sleep_energia_sat", 32'(energia), 32'd5);
        check("sleep_estado_hold", 32'(estado), 32'd6);

        // en_test together with tick: this tick still uses the old mode.
        luz = 1'b1;
        pulse_reset();
        pulse_test();
        @(negedge clk) begin en_test = 1'b1; tick = 1'b1; end
        @(negedge clk) begin en_test = 1'b0; tick = 1'b0; end
        @(negedge clk);
        check("test_tick_saciedad", 32'(saciedad), 32'd4);
        check("test_tick_mode", 32'(test_mode), 32'd0);
        do_tick();
        check("normal_again_saciedad", 32'(saciedad), 32'd4);

        // en_reset together with tick: the tick is dropped, counter at 0.
        @(negedge clk) begin en_reset = 1'b1; tick = 1'b1; end
        @(negedge clk) begin en_reset = 1'b0; tick = 1'b0; end
        check("reset_tick_saciedad", 32'(saciedad), 32'd5);
        ticks(3);
        check("reset_tick_3_saciedad", 32'(saciedad), 32'd5);
        do_tick();
        check("reset_tick_4_saciedad", 32'(saciedad), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
